clock_divider_bank: RTL

//   Parametrised bank of NUM_CH independent 50%-duty clock dividers with runtime-programmable divisors.

---
 rtl/clock_divider_bank_pkg.sv | 20 ++
 rtl/clock_divider_bank_if.sv | 22 ++
 rtl/clock_divider_bank_channel.sv | 70 +++++++
 rtl/clock_divider_bank.sv | 40 ++++
 4 files changed

// File: rtl/clock_divider_bank_pkg.sv
// Shared constants for the divider bank: default counter width, 100 MHz board
// half-periods and a helper converting a target frequency into a half-period.
package clk_div_pkg;

  localparam int CNT_W_DEF = 27;

  localparam int unsigned HALF_1HZ   = 50_000_000;
  localparam int unsigned HALF_10HZ  = 5_000_000;
  localparam int unsigned HALF_100HZ = 500_000;
  localparam int unsigned HALF_2KHZ  = 25_000;

  // Half-period in f_clk cycles; never returns 0 so the compare cannot underflow.
  function automatic int unsigned hz_to_half(input int unsigned f_clk,
                                             input int unsigned f_out);
    int unsigned half;
    half = (f_out == 32'd0) ? 32'd1 : f_clk / (32'd2 * f_out);
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Control and output bundle of the divider bank; the bank is the slave side.
interface clock_divider_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              div_load;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_value;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (output en, sync, div_load, div_ch, div_value,
                  input  clk_out, tick);
  modport slave  (input  en, sync, div_load, div_ch, div_value,
                  output clk_out, tick);
endinterface

// File: rtl/clock_divider_bank_channel.sv
// One divider channel: half-period counter, shadow/active half-period pair,
// toggling output level and a registered rising-edge tick.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic [CNT_W-1:0] half_init,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] load_clamped;
  logic [CNT_W-1:0] init_clamped;
  logic [CNT_W-1:0] shadow_nxt;
  logic [CNT_W-1:0] last_cnt;
  logic             wrap;

  always_comb begin
    load_clamped = (load_value == '0) ? CNT_W'(1) : load_value;
    init_clamped = (half_init == '0) ? CNT_W'(1) : half_init;
    shadow_nxt   = load ? load_clamped : shadow;
    last_cnt     = active - CNT_W'(1);
    // >= rather than == keeps the counter bounded if a disabled-channel load
    // shrinks active below the frozen count.
    wrap         = en && (cnt >= last_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      shadow  <= init_clamped;
      active  <= init_clamped;
    end else if (sync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      shadow  <= shadow_nxt;
      active  <= shadow_nxt;
    end else begin
      shadow <= shadow_nxt;
      if (en) begin
        if (wrap) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          active  <= shadow_nxt;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        if (load) active <= load_clamped;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent 50%-duty dividers; decodes div_load/div_ch into
// per-channel load strobes and holds no state of its own.
module clock_divider_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] HALF_INIT = {CNT_W'(HALF_1HZ), CNT_W'(HALF_10HZ),
                                                  CNT_W'(HALF_100HZ), CNT_W'(HALF_2KHZ)}
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_divider_bank_if.slave  bus
);

  logic [NUM_CH-1:0] clk_out_v;
  logic [NUM_CH-1:0] tick_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load_i;
    // Indices at or above NUM_CH match no channel, so such loads vanish.
    assign load_i = bus.div_load && (int'(bus.div_ch) == i);

    clk_div_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (bus.en[i]),
      .sync       (bus.sync),
      .load       (load_i),
      .load_value (bus.div_value),
      .half_init  (HALF_INIT[i*CNT_W +: CNT_W]),
      .clk_out    (clk_out_v[i]),
      .tick       (tick_v[i])
    );
  end

  assign bus.clk_out = clk_out_v;
  assign bus.tick    = tick_v;

endmodule
